// File: rtl/image_sharpen_3x3.sv
// image_sharpen_3x3: frame-buffered 3x3 Laplacian sharpener (load NxN frame, then stream y = 5c - n - s - w - e)
// Ports: clk (clock), rst_n (async active-low reset), in (pixel, sampled every LOAD edge),
//        out (sharpened pixel, registered, saturated to 0..2^(M+1)-1), out_valid (out carries a result)
module image_sharpen_3x3 #(
  parameter int N = 128,
  parameter int H = 8,
  parameter int M = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [H:0]   in,
  output logic [M:0]   out,
  output logic         out_valid
);
  localparam int NN = N * N;
  localparam int AW = $clog2(NN);
  localparam int CW = $clog2(NN + 1);
  localparam int W  = (H + 6 > M + 3) ? H + 6 : M + 3;
  typedef enum logic {LOAD, OUT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [AW-1:0] ci, row, col;
  logic [H:0] mem [NN];
  logic [H:0] c_q, n_q, s_q, w_q, e_q;
  logic rd, rd_valid;
  logic [W-1:0] y;
  assign ci  = cnt[AW-1:0];
  assign row = ci / AW'(N);
  assign col = ci % AW'(N);
  // cnt reaches NN in OUT only on the drain edge, where no read is issued
  assign rd  = (state == OUT) && (cnt != CW'(NN));
  always_comb begin
    state_nx = (state == LOAD && cnt == CW'(NN - 1)) ? OUT :
               (state == OUT && cnt == CW'(NN))      ? LOAD : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      cnt      <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= (state_nx != state) ? '0 : cnt + CW'(1);
      rd_valid <= rd;
    end
  end
  // frame store and neighbour fetch; zero padding outside the frame, no row wrap
  always_ff @(posedge clk) begin
    if (state == LOAD) mem[ci] <= in;
    if (rd) begin
      c_q <= mem[ci];
      n_q <= (row != '0)          ? mem[ci - AW'(N)] : '0;
      s_q <= (row != AW'(N - 1))  ? mem[ci + AW'(N)] : '0;
      w_q <= (col != '0)          ? mem[ci - AW'(1)] : '0;
      e_q <= (col != AW'(N - 1))  ? mem[ci + AW'(1)] : '0;
    end
  end
  // two's-complement in W bits; top bit set means the result went negative
  assign y = W'(c_q) * W'(5) - W'(n_q) - W'(s_q) - W'(w_q) - W'(e_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= rd_valid;
      if (rd_valid) out <= y[W-1] ? '0 : (y > W'((1 << (M + 1)) - 1)) ? '1 : y[M:0];
    end
  end
endmodule

// File: tb/tb_image_sharpen_3x3.sv
// tb_image_sharpen_3x3: directed bench with frame-level reference model for N=4 and N=128 instances
module tb_image_sharpen_3x3;
  localparam int N1 = 4, NN1 = 16, N2 = 128, NN2 = 16384;
  logic clk = 0, rst_n = 1, rst2_n = 0;
  logic [8:0] in1 = 0, in2 = 0;
  logic [11:0] out1, out2;
  logic v1, v2;
  int checks = 0, errors = 0;
  int mb1 [NN1];
  int mb2 [NN2];
  int got [NN1];
  int t1 = -1, ae1 = -1, t2 = -1, ae2 = -1;
  int last1 = 0, last2 = 0;
  int first_rise = -1, first_fall = -1, rise2 = -1, fall2 = -1, cnt2 = 0;
  bit pv1 = 0, pv2 = 0, chk_en = 0;
  int flat [NN1], imp [NN1], ramp [NN1], rnd [NN1];

  always #5 clk = ~clk;

  image_sharpen_3x3 #(.N(N1), .H(8), .M(11)) u1 (.clk(clk), .rst_n(rst_n), .in(in1), .out(out1), .out_valid(v1));
  image_sharpen_3x3 #(.N(N2), .H(8), .M(11)) u2 (.clk(clk), .rst_n(rst2_n), .in(in2), .out(out2), .out_valid(v2));

  function automatic int nxt(input int t, input int nn);
    return (t == 2 * nn) ? 0 : t + 1;
  endfunction

  function automatic int px(input int which, input int n, input int r, input int c);
    if (r < 0 || c < 0 || r >= n || c >= n) return 0;
    return (which == 1) ? mb1[r * n + c] : mb2[r * n + c];
  endfunction

  function automatic int kern(input int which, input int n, input int j);
    int r, c, y;
    r = j / n;
    c = j % n;
    y = 5 * px(which, n, r, c) - px(which, n, r - 1, c) - px(which, n, r + 1, c)
        - px(which, n, r, c - 1) - px(which, n, r, c + 1);
    return (y < 0) ? 0 : (y > 4095) ? 4095 : y;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // frame position of each instance, counted in edges since the frame began
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      t1 <= -1; ae1 <= -1;
    end else begin
      t1 <= nxt(t1, NN1); ae1 <= ae1 + 1;
      if (nxt(t1, NN1) < NN1) mb1[nxt(t1, NN1)] <= int'(in1);
    end

  always @(posedge clk or negedge rst2_n)
    if (!rst2_n) begin
      t2 <= -1; ae2 <= -1;
    end else begin
      t2 <= nxt(t2, NN2); ae2 <= ae2 + 1;
      if (nxt(t2, NN2) < NN2) mb2[nxt(t2, NN2)] <= int'(in2);
    end

  always @(negedge clk) if (chk_en) begin
    if (t1 == -1) last1 = 0;
    if (t1 >= NN1 + 1 && t1 <= 2 * NN1) begin
      last1 = kern(1, N1, t1 - NN1 - 1);
      got[t1 - NN1 - 1] = int'(out1);
      chk("valid1", int'(v1), 1);
    end else chk("valid1", int'(v1), 0);
    chk("out1", int'(out1), last1);
    if (v1 && !pv1 && first_rise < 0) first_rise = ae1;
    if (!v1 && pv1 && first_fall < 0) first_fall = ae1;
    pv1 = v1;
    if (t2 == -1) last2 = 0;
    if (t2 >= NN2 + 1 && t2 <= 2 * NN2) begin
      last2 = kern(2, N2, t2 - NN2 - 1);
      chk("valid2", int'(v2), 1);
    end else chk("valid2", int'(v2), 0);
    chk("out2", int'(out2), last2);
    if (v2) cnt2++;
    if (v2 && !pv2 && rise2 < 0) rise2 = ae2;
    if (!v2 && pv2 && fall2 < 0) fall2 = ae2;
    pv2 = v2;
  end

  task automatic run1(input int img [NN1], input int edges);
    for (int k = 0; k < edges; k++) begin
      in1 = (k < NN1) ? 9'(img[k]) : 9'($urandom);
      @(negedge clk);
    end
  endtask

  initial begin
    for (int k = 0; k < NN1; k++) begin
      flat[k] = 100;
      imp[k]  = (k == 5) ? 511 : 0;
      ramp[k] = k;
    end
    #1 rst_n = 0;
    #1 chk_en = 1;
    repeat (3) @(negedge clk);
    #1 chk("rst_out", int'(out1), 0);
    chk("rst_valid", int'(v1), 0);
    @(negedge clk) rst_n = 1;
    run1(flat, 2 * NN1 + 1);
    #1 chk("flat_corner", got[0], 300);
    chk("flat_edge", got[1], 200);
    chk("flat_inner", got[5], 100);
    chk("flat_corner15", got[15], 300);
    run1(imp, 2 * NN1 + 1);
    #1 chk("imp_center", got[5], 2555);
    chk("imp_n", got[1], 0);
    chk("imp_w", got[4], 0);
    chk("imp_e", got[6], 0);
    chk("imp_s", got[9], 0);
    chk("first_rise", first_rise, 17);
    chk("first_fall", first_fall, 33);
    run1(ramp, 2 * NN1 + 1);
    #1 chk("ramp_00", got[0], 0);
    chk("ramp_11", got[5], 5);
    chk("ramp_03", got[3], 6);
    chk("ramp_33", got[15], 50);
    for (int k = 0; k < NN1; k++) rnd[k] = ($urandom_range(0, 2) == 0) ? 511 : int'($urandom_range(0, 511));
    run1(rnd, NN1 + 4);
    #2 rst_n = 0;
    #1 chk("midout_rst_out", int'(out1), 0);
    chk("midout_rst_valid", int'(v1), 0);
    @(negedge clk) rst_n = 1;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < NN1; k++)
        rnd[k] = ($urandom_range(0, 3) == 0) ? 0 : ($urandom_range(0, 2) == 0) ? 511 : int'($urandom_range(0, 511));
      run1(rnd, 2 * NN1 + 1);
    end
    rst_n = 0;
    @(negedge clk) rst2_n = 1;
    for (int k = 0; k < 2 * NN2 + 1; k++) begin
      in2 = (k < NN2) ? 9'((k * 37 + k / 128) % 512) : 9'($urandom);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    #1 chk("n128_first", rise2, NN2 + 1);
    chk("n128_count", cnt2, NN2);
    chk("n128_fall", fall2, 2 * NN2 + 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
